// File: rtl/msrh_l1d_lrq_pkg.sv
// Shared L1D load-miss queue definitions: L2 command tag layout, entry state
// and the per-entry record.
package msrh_l1d_lrq_pkg;

    localparam int unsigned LRQ_ENTRY_NUM  = 8;
    localparam int unsigned LRQ_ENTRY_W    = $clog2(LRQ_ENTRY_NUM);
    localparam int unsigned L2_CMD_TAG_W   = 8;
    localparam logic [1:0]  L2_UPPER_TAG_L1D = 2'b01;
    localparam int unsigned LRQ_PADDR_W    = 40;
    localparam int unsigned LRQ_LINE_OFS_W = 6;
    localparam int unsigned LRQ_LINE_W     = LRQ_PADDR_W - LRQ_LINE_OFS_W;

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_ISSUE = 2'd1,
        ISSUING    = 2'd2,
        WAIT_RESP  = 2'd3
    } lrq_state_t;

    typedef struct packed {
        lrq_state_t              state;
        logic [LRQ_LINE_W-1:0]   line_addr;
    } lrq_entry_t;

endpackage

// File: rtl/msrh_l1d_lrq_entry.sv
// One load-miss queue entry: lifecycle state, stored line address and a
// per-request-port line match.
module msrh_l1d_lrq_entry
    import msrh_l1d_lrq_pkg::*;
#(
    parameter int unsigned REQ_PORT_NUM = 2
)(
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic                                   i_alloc,
    input  logic [LRQ_LINE_W-1:0]                  i_alloc_line,
    input  logic                                   i_issue_sel,
    input  logic                                   i_issue_ack,
    input  logic                                   i_free,
    input  logic [REQ_PORT_NUM-1:0][LRQ_LINE_W-1:0] i_cmp_line,
    output logic [REQ_PORT_NUM-1:0]                o_hit,
    output lrq_state_t                             o_state,
    output logic [LRQ_LINE_W-1:0]                  o_line
);

    lrq_entry_t r_entry;
    lrq_entry_t w_entry_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_entry <= '{state: FREE, line_addr: '0};
        end else begin
            r_entry <= w_entry_nxt;
        end
    end

    // An entry allocated while the issue stage is empty goes straight to ISSUING.
    always_comb begin
        w_entry_nxt = r_entry;
        case (r_entry.state)
            FREE: begin
                if (i_alloc) begin
                    w_entry_nxt.line_addr = i_alloc_line;
                    w_entry_nxt.state     = i_issue_sel ? ISSUING : WAIT_ISSUE;
                end
            end
            WAIT_ISSUE: if (i_issue_sel) w_entry_nxt.state = ISSUING;
            ISSUING:    if (i_issue_ack) w_entry_nxt.state = WAIT_RESP;
            WAIT_RESP:  if (i_free)      w_entry_nxt.state = FREE;
            default:    w_entry_nxt.state = FREE;
        endcase
    end

    always_comb begin
        o_hit = '0;
        for (int unsigned p = 0; p < REQ_PORT_NUM; p++) begin
            o_hit[p] = (r_entry.state != FREE) && (r_entry.line_addr == i_cmp_line[p]);
        end
    end

    assign o_state = r_entry.state;
    assign o_line  = r_entry.line_addr;

endmodule

// File: rtl/msrh_l1d_lrq.sv
// L1D load-miss request queue: merges/allocates LSU misses, issues line fills
// to L2 tagged by entry index, and frees entries on the cache response search.
module msrh_l1d_lrq
    import msrh_l1d_lrq_pkg::*;
#(
    parameter int unsigned ENTRY_NUM    = LRQ_ENTRY_NUM,
    parameter int unsigned REQ_PORT_NUM = 2,
    parameter int unsigned PADDR_W      = LRQ_PADDR_W,
    parameter int unsigned LINE_OFS_W   = LRQ_LINE_OFS_W,
    parameter int unsigned L2_TAG_W     = L2_CMD_TAG_W,
    localparam int unsigned ENTRY_W     = $clog2(ENTRY_NUM)
)(
    input  logic                                  i_clk,
    input  logic                                  i_reset_n,
    input  logic [REQ_PORT_NUM-1:0]               i_miss_valid,
    input  logic [REQ_PORT_NUM-1:0][PADDR_W-1:0]  i_miss_paddr,
    output logic [REQ_PORT_NUM-1:0]               o_miss_resp_valid,
    output logic [REQ_PORT_NUM-1:0]               o_miss_resp_merged,
    output logic [REQ_PORT_NUM-1:0]               o_miss_resp_full,
    output logic [REQ_PORT_NUM-1:0][ENTRY_W-1:0]  o_miss_resp_index,
    output logic                                  o_l2_req_valid,
    input  logic                                  i_l2_req_ready,
    output logic [L2_TAG_W-1:0]                   o_l2_req_tag,
    output logic [PADDR_W-1:0]                    o_l2_req_paddr,
    input  logic                                  i_search_valid,
    input  logic [ENTRY_W-1:0]                    i_search_index,
    output logic [PADDR_W-1:0]                    o_search_paddr,
    output logic                                  o_search_error,
    output logic                                  o_fill_valid,
    output logic [ENTRY_W-1:0]                    o_fill_index,
    output logic [ENTRY_W:0]                      o_free_count
);

    localparam int unsigned LINE_W = PADDR_W - LINE_OFS_W;

    lrq_state_t                        w_state      [ENTRY_NUM];
    logic [LINE_W-1:0]                 w_line       [ENTRY_NUM];
    logic [REQ_PORT_NUM-1:0]           w_hit        [ENTRY_NUM];
    logic [LINE_W-1:0]                 w_alloc_line [ENTRY_NUM];
    logic [REQ_PORT_NUM-1:0][LINE_W-1:0] w_req_line;
    logic [ENTRY_NUM-1:0]              w_alloc;
    logic [ENTRY_NUM-1:0]              w_free;
    logic [ENTRY_NUM-1:0]              w_sel_vec;
    logic [ENTRY_NUM-1:0]              w_ack_vec;
    logic [REQ_PORT_NUM-1:0]           w_port_alloc;
    logic                              w_sel_found;
    logic [ENTRY_W-1:0]                w_sel_idx;
    logic [LINE_W-1:0]                 w_sel_line;
    logic [ENTRY_W:0]                  w_alloc_cnt;

    logic                              r_iss_valid;
    logic [ENTRY_W-1:0]                r_iss_idx;
    logic [LINE_W-1:0]                 r_iss_line;
    logic                              r_fill_valid;
    logic [ENTRY_W-1:0]                r_fill_idx;
    logic [ENTRY_W:0]                  r_free_count;

    for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_entry
        msrh_l1d_lrq_entry #(
            .REQ_PORT_NUM (REQ_PORT_NUM)
        ) u_entry (
            .i_clk        (i_clk),
            .i_reset_n    (i_reset_n),
            .i_alloc      (w_alloc[e]),
            .i_alloc_line (w_alloc_line[e]),
            .i_issue_sel  (w_sel_vec[e]),
            .i_issue_ack  (w_ack_vec[e]),
            .i_free       (w_free[e]),
            .i_cmp_line   (w_req_line),
            .o_hit        (w_hit[e]),
            .o_state      (w_state[e]),
            .o_line       (w_line[e])
        );
    end

    always_comb begin
        w_req_line = '0;
        for (int unsigned p = 0; p < REQ_PORT_NUM; p++) begin
            w_req_line[p] = i_miss_paddr[p][PADDR_W-1:LINE_OFS_W];
        end
    end

    always_comb begin
        w_free    = '0;
        w_ack_vec = '0;
        for (int unsigned e = 0; e < ENTRY_NUM; e++) begin
            w_free[e]    = i_search_valid && (i_search_index == ENTRY_W'(e)) &&
                           (w_state[e] == WAIT_RESP);
            w_ack_vec[e] = r_iss_valid && i_l2_req_ready && (r_iss_idx == ENTRY_W'(e));
        end
    end

    // Ports resolve in order: existing entry, then a lower port's fresh
    // allocation, then the lowest FREE entry not claimed by a lower port.
    always_comb begin
        logic found;
        o_miss_resp_valid  = '0;
        o_miss_resp_merged = '0;
        o_miss_resp_full   = '0;
        o_miss_resp_index  = '0;
        w_alloc            = '0;
        w_alloc_line       = '{default: '0};
        w_port_alloc       = '0;
        for (int unsigned p = 0; p < REQ_PORT_NUM; p++) begin
            found = 1'b0;
            if (i_miss_valid[p]) begin
                o_miss_resp_valid[p] = 1'b1;
                for (int unsigned e = 0; e < ENTRY_NUM; e++) begin
                    if (!found && w_hit[e][p] && !w_free[e]) begin
                        found                 = 1'b1;
                        o_miss_resp_merged[p] = 1'b1;
                        o_miss_resp_index[p]  = ENTRY_W'(e);
                    end
                end
                for (int unsigned q = 0; q < p; q++) begin
                    if (!found && w_port_alloc[q] && (w_req_line[q] == w_req_line[p])) begin
                        found                 = 1'b1;
                        o_miss_resp_merged[p] = 1'b1;
                        o_miss_resp_index[p]  = o_miss_resp_index[q];
                    end
                end
                for (int unsigned e = 0; e < ENTRY_NUM; e++) begin
                    if (!found && (w_state[e] == FREE) && !w_alloc[e]) begin
                        found                = 1'b1;
                        w_alloc[e]           = 1'b1;
                        w_alloc_line[e]      = w_req_line[p];
                        w_port_alloc[p]      = 1'b1;
                        o_miss_resp_index[p] = ENTRY_W'(e);
                    end
                end
                o_miss_resp_full[p] = !found;
            end
        end
    end

    // Entries allocated this cycle are eligible so a lone miss issues next cycle.
    always_comb begin
        w_sel_vec   = '0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_line  = '0;
        if (!r_iss_valid) begin
            for (int unsigned e = 0; e < ENTRY_NUM; e++) begin
                if (!w_sel_found && ((w_state[e] == WAIT_ISSUE) || w_alloc[e])) begin
                    w_sel_found  = 1'b1;
                    w_sel_vec[e] = 1'b1;
                    w_sel_idx    = ENTRY_W'(e);
                    w_sel_line   = w_alloc[e] ? w_alloc_line[e] : w_line[e];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_iss_valid <= 1'b0;
            r_iss_idx   <= '0;
            r_iss_line  <= '0;
        end else if (w_sel_found) begin
            r_iss_valid <= 1'b1;
            r_iss_idx   <= w_sel_idx;
            r_iss_line  <= w_sel_line;
        end else if (r_iss_valid && i_l2_req_ready) begin
            r_iss_valid <= 1'b0;
        end
    end

    assign w_alloc_cnt = (ENTRY_W+1)'($countones(w_alloc));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_fill_valid <= 1'b0;
            r_fill_idx   <= '0;
            r_free_count <= (ENTRY_W+1)'(ENTRY_NUM);
        end else begin
            r_fill_valid <= |w_free;
            r_fill_idx   <= i_search_index;
            r_free_count <= r_free_count - w_alloc_cnt + (ENTRY_W+1)'(|w_free);
        end
    end

    always_comb begin
        o_l2_req_tag                    = '0;
        o_l2_req_tag[L2_TAG_W-1 -: 2]   = L2_UPPER_TAG_L1D;
        o_l2_req_tag[ENTRY_W-1:0]       = r_iss_idx;
    end

    assign o_l2_req_valid = r_iss_valid;
    assign o_l2_req_paddr = {r_iss_line, {LINE_OFS_W{1'b0}}};
    assign o_search_paddr = {w_line[i_search_index], {LINE_OFS_W{1'b0}}};
    assign o_search_error = i_search_valid && (w_state[i_search_index] != WAIT_RESP);
    assign o_fill_valid   = r_fill_valid;
    assign o_fill_index   = r_fill_idx;
    assign o_free_count   = r_free_count;

endmodule

// File: tb/tb_msrh_l1d_lrq.sv
// Self-checking bench for msrh_l1d_lrq: directed scenarios with literal
// expectations, then randomized traffic against a behavioural queue model.
module tb_msrh_l1d_lrq;

    localparam int M_FREE = 0;
    localparam int M_WI   = 1;
    localparam int M_ISS  = 2;
    localparam int M_WR   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mv;
    logic [1:0][39:0]  mpa;
    logic              rdy;
    logic              sv;
    logic [2:0]        sidx;

    logic [1:0]        o_miss_resp_valid;
    logic [1:0]        o_miss_resp_merged;
    logic [1:0]        o_miss_resp_full;
    logic [1:0][2:0]   o_miss_resp_index;
    logic              o_l2_req_valid;
    logic [7:0]        o_l2_req_tag;
    logic [39:0]       o_l2_req_paddr;
    logic [39:0]       o_search_paddr;
    logic              o_search_error;
    logic              o_fill_valid;
    logic [2:0]        o_fill_index;
    logic [3:0]        o_free_count;

    always #5 clk = ~clk;

    msrh_l1d_lrq #(
        .ENTRY_NUM    (8),
        .REQ_PORT_NUM (2),
        .PADDR_W      (40),
        .LINE_OFS_W   (6),
        .L2_TAG_W     (8)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_miss_valid       (mv),
        .i_miss_paddr       (mpa),
        .o_miss_resp_valid  (o_miss_resp_valid),
        .o_miss_resp_merged (o_miss_resp_merged),
        .o_miss_resp_full   (o_miss_resp_full),
        .o_miss_resp_index  (o_miss_resp_index),
        .o_l2_req_valid     (o_l2_req_valid),
        .i_l2_req_ready     (rdy),
        .o_l2_req_tag       (o_l2_req_tag),
        .o_l2_req_paddr     (o_l2_req_paddr),
        .i_search_valid     (sv),
        .i_search_index     (sidx),
        .o_search_paddr     (o_search_paddr),
        .o_search_error     (o_search_error),
        .o_fill_valid       (o_fill_valid),
        .o_fill_index       (o_fill_index),
        .o_free_count       (o_free_count)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: per-entry lifecycle and line, the single issue slot, the fill flag.
    int           mst [8];
    logic [33:0]  mln [8];
    bit           m_iv;
    int           m_ii;
    logic [33:0]  m_il;
    bit           m_fv;
    int           m_fi;

    bit  e_merged [2];
    bit  e_full   [2];
    int  e_idx    [2];
    bit  e_alloc  [2];
    bit  e_free;
    bit  e_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_free_cnt();
        int n = 0;
        for (int e = 0; e < 8; e++) if (mst[e] == M_FREE) n++;
        return n;
    endfunction

    task automatic model_eval();
        bit taken [8];
        for (int e = 0; e < 8; e++) taken[e] = 1'b0;
        e_free = sv && (mst[sidx] == M_WR);
        e_err  = sv && (mst[sidx] != M_WR);
        for (int p = 0; p < 2; p++) begin
            logic [33:0] line;
            bit done;
            e_merged[p] = 1'b0; e_full[p] = 1'b0; e_idx[p] = 0; e_alloc[p] = 1'b0;
            done = 1'b0;
            line = mpa[p][39:6];
            if (mv[p]) begin
                for (int e = 0; e < 8; e++)
                    if (!done && mst[e] != M_FREE && mln[e] == line && !(e_free && e == int'(sidx))) begin
                        done = 1'b1; e_merged[p] = 1'b1; e_idx[p] = e;
                    end
                for (int q = 0; q < p; q++)
                    if (!done && e_alloc[q] && mpa[q][39:6] == line) begin
                        done = 1'b1; e_merged[p] = 1'b1; e_idx[p] = e_idx[q];
                    end
                for (int e = 0; e < 8; e++)
                    if (!done && mst[e] == M_FREE && !taken[e]) begin
                        done = 1'b1; taken[e] = 1'b1; e_alloc[p] = 1'b1; e_idx[p] = e;
                    end
                e_full[p] = !done;
            end
        end
    endtask

    task automatic model_compare();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("m_resp_valid%0d", p),  o_miss_resp_valid[p],  mv[p]);
            chk($sformatf("m_resp_merged%0d", p), o_miss_resp_merged[p], e_merged[p]);
            chk($sformatf("m_resp_full%0d", p),   o_miss_resp_full[p],   e_full[p]);
            chk($sformatf("m_resp_index%0d", p),  o_miss_resp_index[p],  e_idx[p]);
        end
        if (sv && mst[sidx] != M_FREE) chk("m_search_paddr", o_search_paddr, {mln[sidx], 6'b0});
        chk("m_search_error", o_search_error, e_err);
        chk("m_l2_valid", o_l2_req_valid, m_iv);
        if (m_iv) begin
            chk("m_l2_tag",   o_l2_req_tag,   8'h40 | 8'(m_ii));
            chk("m_l2_paddr", o_l2_req_paddr, {m_il, 6'b0});
        end
        chk("m_fill_valid", o_fill_valid, m_fv);
        if (m_fv) chk("m_fill_index", o_fill_index, m_fi);
        chk("m_free_count", o_free_count, model_free_cnt());
    endtask

    task automatic model_update();
        int sel;
        if (!rst_n) begin
            for (int e = 0; e < 8; e++) begin mst[e] = M_FREE; mln[e] = '0; end
            m_iv = 1'b0; m_ii = 0; m_il = '0; m_fv = 1'b0; m_fi = 0;
            return;
        end
        sel = -1;
        if (!m_iv)
            for (int e = 7; e >= 0; e--)
                if (mst[e] == M_WI || (e_alloc[0] && e_idx[0] == e) || (e_alloc[1] && e_idx[1] == e))
                    sel = e;
        for (int p = 0; p < 2; p++)
            if (e_alloc[p]) begin mst[e_idx[p]] = M_WI; mln[e_idx[p]] = mpa[p][39:6]; end
        if (e_free) mst[sidx] = M_FREE;
        m_fv = e_free;
        m_fi = int'(sidx);
        if (m_iv && rdy) begin mst[m_ii] = M_WR; m_iv = 1'b0; end
        if (sel >= 0) begin mst[sel] = M_ISS; m_iv = 1'b1; m_ii = sel; m_il = mln[sel]; end
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        if (cmp_en) model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr();
        mv = '0; mpa = '0; rdy = 1'b0; sv = 1'b0; sidx = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        clr();
        tick(); tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        chk("rst_free_count", o_free_count, 8);
        chk("rst_l2_valid", o_l2_req_valid, 0);
        chk("rst_fill_valid", o_fill_valid, 0);
        chk("rst_resp_valid", o_miss_resp_valid, 0);

        // single miss through issue, search and fill
        mv = 2'b01; mpa[0] = 40'h10_0000_48; #2;
        chk("t1_resp_valid", o_miss_resp_valid[0], 1);
        chk("t1_merged", o_miss_resp_merged[0], 0);
        chk("t1_full", o_miss_resp_full[0], 0);
        chk("t1_index", o_miss_resp_index[0], 0);
        tick(); clr();
        chk("t1_l2_valid", o_l2_req_valid, 1);
        chk("t1_l2_paddr", o_l2_req_paddr, 40'h10_0000_40);
        chk("t1_l2_tag", o_l2_req_tag, 8'h40);
        rdy = 1'b1; tick(); rdy = 1'b0;
        sv = 1'b1; sidx = 3'd0; #2;
        chk("t1_search_paddr", o_search_paddr, 40'h10_0000_40);
        chk("t1_search_error", o_search_error, 0);
        tick(); sv = 1'b0;
        chk("t1_fill_valid", o_fill_valid, 1);
        chk("t1_fill_index", o_fill_index, 0);

        // same-line misses on both ports in one cycle
        mv = 2'b11; mpa[0] = 40'h20_0000_00; mpa[1] = 40'h20_0000_10; #2;
        chk("t2_p0_merged", o_miss_resp_merged[0], 0);
        chk("t2_p0_index", o_miss_resp_index[0], 0);
        chk("t2_p1_merged", o_miss_resp_merged[1], 1);
        chk("t2_p1_index", o_miss_resp_index[1], 0);
        tick(); clr();
        n = 0; rdy = 1'b1;
        repeat (6) begin
            if (o_l2_req_valid) n++;
            tick();
        end
        rdy = 1'b0;
        chk("t2_l2_req_count", n, 1);
        sv = 1'b1; sidx = 3'd0; tick(); sv = 1'b0;

        // fill all entries, then overflow
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mv = 2'b11;
            mpa[0] = 40'h30_0000_00 + 40'(2*i) * 64;
            mpa[1] = 40'h30_0000_00 + 40'(2*i+1) * 64;
            tick();
        end
        mv = 2'b01; mpa[0] = 40'h40_0000_00; mpa[1] = '0; #2;
        chk("t3_full", o_miss_resp_full[0], 1);
        chk("t3_full_index", o_miss_resp_index[0], 0);
        chk("t3_free_count", o_free_count, 0);
        tick(); clr();
        rdy = 1'b1; repeat (20) tick(); rdy = 1'b0;
        sv = 1'b1; sidx = 3'd3; tick(); sv = 1'b0;
        chk("t3_free_after_search", o_free_count, 1);

        // miss to a line whose entry is freed this very cycle
        mv = 2'b01; mpa[0] = 40'h30_0000_80; sv = 1'b1; sidx = 3'd2; #2;
        chk("t4_merged", o_miss_resp_merged[0], 0);
        chk("t4_full", o_miss_resp_full[0], 0);
        chk("t4_index", o_miss_resp_index[0], 3);
        tick(); clr();
        chk("t4_l2_valid", o_l2_req_valid, 1);
        chk("t4_l2_tag", o_l2_req_tag, 8'h43);
        chk("t4_l2_paddr", o_l2_req_paddr, 40'h30_0000_80);

        // reset with entries outstanding
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t7_free_count", o_free_count, 8);
        chk("t7_l2_valid", o_l2_req_valid, 0);
        chk("t7_fill_valid", o_fill_valid, 0);
        chk("t7_search_error", o_search_error, 0);

        // stalled L2 with a lower-index allocation during the stall
        mv = 2'b11; mpa[0] = 40'h50_0000_00; mpa[1] = 40'h50_0000_40; tick(); clr();
        rdy = 1'b1; tick(); rdy = 1'b0;
        sv = 1'b1; sidx = 3'd0; tick(); sv = 1'b0;
        chk("t5_l2_tag_start", o_l2_req_tag, 8'h41);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                mv = 2'b01; mpa[0] = 40'h50_0000_80; #2;
                chk("t5_alloc_index", o_miss_resp_index[0], 0);
            end
            tick(); clr();
            chk("t5_stall_valid", o_l2_req_valid, 1);
            chk("t5_stall_tag", o_l2_req_tag, 8'h41);
            chk("t5_stall_paddr", o_l2_req_paddr, 40'h50_0000_40);
        end

        // search of a FREE entry
        sv = 1'b1; sidx = 3'd5; #2;
        chk("t6_search_error", o_search_error, 1);
        tick(); sv = 1'b0;
        chk("t6_fill_valid", o_fill_valid, 0);
        chk("t6_free_count", o_free_count, 6);

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            int wr_list [$];
            rst_n = ($urandom_range(0, 499) != 0);
            mv = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++)
                mpa[p] = 40'h70_0000_00 + 40'($urandom_range(0, 11)) * 64 + 40'($urandom_range(0, 63));
            rdy = 1'($urandom_range(0, 1));
            sv  = ($urandom_range(0, 2) != 0);
            for (int e = 0; e < 8; e++) if (mst[e] == M_WR) wr_list.push_back(e);
            if (wr_list.size() > 0 && $urandom_range(0, 3) != 0)
                sidx = 3'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
            else
                sidx = 3'($urandom_range(0, 7));
            tick();
        end
        rst_n = 1'b1;
        clr();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
